alu_flags_stage: RTL

ALU_FLAGS_STAGE -- requirements
Module: alu_flags_stage

---
 rtl/alu_flags_stage_pkg.sv | 20 ++
 rtl/alu_flag_calc.sv | 32 +++
 rtl/alu_flags_stage.sv | 113 +++++++++++
 3 files changed

// File: rtl/alu_flags_stage_pkg.sv
// rtl/alu_flags_stage_pkg.sv - shared ALU constants: width, flag bit positions, mode and stage state encodings
package alu_flags_stage_pkg;

   localparam int ALU_WIDTH = 64;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } stage_state_t;

endpackage

// File: rtl/alu_flag_calc.sv
// rtl/alu_flag_calc.sv - combinational N/Z/C/V flag generation from adder operands and result
module alu_flag_calc
   import alu_flags_stage_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_mode,
   input  logic [WIDTH-1:0] i_sum,
   input  logic             i_cout,
   output logic [3:0]       o_flags
);

   logic w_sign_same;
   logic w_sign_flip;
   logic w_ovf;

   // Subtract overflows when operand signs differ, add when they match; either way the sum sign left a's.
   assign w_sign_same = (i_a[WIDTH-1] == i_b[WIDTH-1]);
   assign w_sign_flip = (i_sum[WIDTH-1] != i_a[WIDTH-1]);
   assign w_ovf       = ((i_mode == MODE_SUB) ? !w_sign_same : w_sign_same) && w_sign_flip;

   always_comb begin
      o_flags         = '0;
      o_flags[FLAG_N] = i_sum[WIDTH-1];
      o_flags[FLAG_Z] = (i_sum == '0);
      o_flags[FLAG_C] = i_cout;
      o_flags[FLAG_V] = w_ovf;
   end

endmodule

// File: rtl/alu_flags_stage.sv
// rtl/alu_flags_stage.sv - registers adder result plus flags through a two-entry skid buffer
module alu_flags_stage
   import alu_flags_stage_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_mode,
   input  logic [WIDTH-1:0] in_sum,
   input  logic             in_cout,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic [3:0]       out_flags
);

   stage_state_t     r_state;
   stage_state_t     w_state_nxt;
   logic             r_in_ready;
   logic [WIDTH-1:0] r_main_result;
   logic [3:0]       r_main_flags;
   logic [WIDTH-1:0] r_skid_result;
   logic [3:0]       r_skid_flags;

   logic [3:0]       w_flags;
   logic             w_cap;
   logic             w_xfer;
   logic             w_load_main_in;
   logic             w_load_main_skid;
   logic             w_load_skid;

   alu_flag_calc #(.WIDTH(WIDTH)) u_flag_calc (
      .i_a     (in_a),
      .i_b     (in_b),
      .i_mode  (in_mode),
      .i_sum   (in_sum),
      .i_cout  (in_cout),
      .o_flags (w_flags)
   );

   assign in_ready   = r_in_ready;
   assign out_valid  = (r_state != ST_EMPTY);
   assign out_result = r_main_result;
   assign out_flags  = r_main_flags;

   assign w_cap  = in_valid && r_in_ready;
   assign w_xfer = out_valid && out_ready;

   always_comb begin
      w_state_nxt      = r_state;
      w_load_main_in   = 1'b0;
      w_load_main_skid = 1'b0;
      w_load_skid      = 1'b0;
      unique case (r_state)
         ST_EMPTY: begin
            if (w_cap) begin
               w_load_main_in = 1'b1;
               w_state_nxt    = ST_ONE;
            end
         end
         ST_ONE: begin
            if (w_cap && w_xfer) begin
               w_load_main_in = 1'b1;
            end else if (w_cap) begin
               w_load_skid = 1'b1;
               w_state_nxt = ST_TWO;
            end else if (w_xfer) begin
               w_state_nxt = ST_EMPTY;
            end
         end
         ST_TWO: begin
            if (w_xfer) begin
               w_load_main_skid = 1'b1;
               w_state_nxt      = ST_ONE;
            end
         end
         default: w_state_nxt = ST_EMPTY;
      endcase
   end

   // in_ready is precomputed from the next state so it never depends on out_ready in the same cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= ST_EMPTY;
         r_in_ready    <= 1'b1;
         r_main_result <= '0;
         r_main_flags  <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_in_ready <= (w_state_nxt != ST_TWO);
         if (w_load_main_in) begin
            r_main_result <= in_sum;
            r_main_flags  <= w_flags;
         end else if (w_load_main_skid) begin
            r_main_result <= r_skid_result;
            r_main_flags  <= r_skid_flags;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_load_skid) begin
         r_skid_result <= in_sum;
         r_skid_flags  <= w_flags;
      end
   end

endmodule
